// File: rtl/chu_mmio_master.sv
// rtl/chu_mmio_master.sv - MMIO slot-bus initiator with command FIFO and in-order read response
module chu_mmio_master #(
  parameter int SLOT_BITS  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [SLOT_BITS+4:0]            cmd_addr,
  input  logic [31:0]                     cmd_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [31:0]                     rsp_rdata,
  output logic [(1<<SLOT_BITS)-1:0]       slot_cs,
  output logic                            slot_read,
  output logic                            slot_write,
  output logic [4:0]                      slot_addr,
  output logic [31:0]                     slot_wdata,
  input  logic [32*(1<<SLOT_BITS)-1:0]    slot_rdata,
  output logic                            busy
);

  localparam int NSLOT = 1 << SLOT_BITS;
  localparam int AW    = SLOT_BITS + 5;
  localparam int EW    = 1 + AW + 32;
  localparam int PW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nxt;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, push, pop, capture;

  logic                 iss_write;
  logic [AW-1:0]        iss_addr;
  logic [31:0]          iss_wdata;
  logic [SLOT_BITS-1:0] iss_slot;
  logic [31:0]          rd_word [NSLOT];

  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NSLOT; g++) begin : g_rd
      assign rd_word[g] = slot_rdata[32*g +: 32];
    end
  endgenerate

  assign iss_slot = iss_addr[AW-1:5];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      iss_write <= 1'b0;
      iss_addr  <= '0;
      iss_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (pop)     {iss_write, iss_addr, iss_wdata} <= mem[rd_ptr];
      if (capture) rsp_rdata <= rd_word[iss_slot];
    end
  end

  // Writes chain back-to-back in ISSUE; a read always parks in RESP until handshaken.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (iss_write) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = IDLE;
        end else begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign slot_cs    = (state == ISSUE) ? (NSLOT'(1) << iss_slot) : '0;
  assign slot_write = (state == ISSUE) && iss_write;
  assign slot_read  = (state == ISSUE) && !iss_write;
  assign slot_addr  = iss_addr[4:0];
  assign slot_wdata = iss_wdata;
  assign rsp_valid  = (state == RESP);
  assign busy       = !empty || (state != IDLE);

endmodule

// File: tb/tb_chu_mmio_master.sv
// tb/tb_chu_mmio_master.sv - directed-vector bench for chu_mmio_master
module tb_chu_mmio_master;

  localparam int SB = 6;
  localparam int NS = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [SB+4:0]     cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_rdata;
  logic [NS-1:0]     slot_cs;
  logic              slot_read, slot_write;
  logic [4:0]        slot_addr;
  logic [31:0]       slot_wdata;
  logic [32*NS-1:0]  slot_rdata;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  int nw, first, k;
  int s3 [6] = '{1, 2, 3, 4, 6, 7};

  always #5 clk = ~clk;

  chu_mmio_master #(.SLOT_BITS(SB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .slot_cs(slot_cs), .slot_read(slot_read), .slot_write(slot_write),
    .slot_addr(slot_addr), .slot_wdata(slot_wdata), .slot_rdata(slot_rdata),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_pat(input int s);
    if (s == 5)  return 32'h1234_5678;
    if (s == 63) return 32'hCAFE_F00D;
    return 32'hA500_0000 | 32'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input int s, input int r, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = {6'(s), 5'(r)};
    cmd_wdata = d;
  endtask

  task automatic wait_rsp(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) check(tag, 64'd0, 64'd1);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0;
    for (int s = 0; s < NS; s++) slot_rdata[32*s +: 32] = rd_pat(s);

    repeat (2) @(negedge clk);
    check("rst_cs", 64'(slot_cs), 64'd0);
    check("rst_strobes", {62'd0, slot_read, slot_write}, 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_slot_addr", 64'(slot_addr), 64'd0);
    check("rst_slot_wdata", 64'(slot_wdata), 64'd0);
    step();

    // single write
    drive(1'b1, 3, 0, 32'h0000_00A5);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("wr_wait_strobe", 64'(slot_write), 64'd0);
    check("wr_wait_busy", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    check("wr_write", 64'(slot_write), 64'd1);
    check("wr_read", 64'(slot_read), 64'd0);
    check("wr_cs", 64'(slot_cs), 64'h8);
    check("wr_addr", 64'(slot_addr), 64'd0);
    check("wr_wdata", 64'(slot_wdata), 64'hA5);
    check("wr_no_rsp", 64'(rsp_valid), 64'd0);
    step();
    @(negedge clk);
    check("wr_end_strobe", 64'(slot_write), 64'd0);
    check("wr_end_cs", 64'(slot_cs), 64'd0);
    check("wr_end_rsp", 64'(rsp_valid), 64'd0);
    check("wr_end_busy", 64'(busy), 64'd0);
    check("wr_hold_wdata", 64'(slot_wdata), 64'hA5);
    step();

    // single read, response two cycles after acceptance
    drive(1'b0, 5, 1, 32'd0);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rd_wait_rsp", 64'(rsp_valid), 64'd0);
    step();
    @(negedge clk);
    check("rd_read", 64'(slot_read), 64'd1);
    check("rd_cs", 64'(slot_cs), 64'h20);
    check("rd_addr", 64'(slot_addr), 64'd1);
    check("rd_rsp_early", 64'(rsp_valid), 64'd0);
    step();
    @(negedge clk);
    check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    check("rd_rdata", 64'(rsp_rdata), 64'h1234_5678);
    check("rd_read_off", 64'(slot_read), 64'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rd_rsp_done", 64'(rsp_valid), 64'd0);
    check("rd_busy_done", 64'(busy), 64'd0);
    step();

    // backpressure: fill FIFO behind a stalled read
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, s3[i], i, 32'd0);
      @(negedge clk);
      check("fill_ready", 64'(cmd_ready), 64'd1);
      step();
    end
    drive(1'b0, s3[5], 5, 32'd0);
    @(negedge clk);
    check("full_ready", 64'(cmd_ready), 64'd0);
    check("full_rsp_valid", 64'(rsp_valid), 64'd1);
    check("full_rdata", 64'(rsp_rdata), 64'(rd_pat(1)));
    step();
    @(negedge clk);
    check("full_ready_hold", 64'(cmd_ready), 64'd0);
    check("full_rdata_stable", 64'(rsp_rdata), 64'(rd_pat(1)));
    check("full_valid_stable", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("pop_issue_read", 64'(slot_read), 64'd1);
    check("pop_issue_cs", 64'(slot_cs), 64'h4);
    check("pop_cmd_ready", 64'(cmd_ready), 64'd1);
    check("pop_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid && k < 5) begin
        check("resp_order", 64'(rsp_rdata), 64'(rd_pat(s3[k+1])));
        k++;
      end
      step();
    end
    check("resp_count", 64'(k), 64'd5);
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_busy_done", 64'(busy), 64'd0);
    step();

    // back-to-back writes
    nw = 0;
    first = -1;
    fork
      begin
        drive(1'b1, 0, 0, 32'h100);
        step();
        drive(1'b1, 0, 1, 32'h101);
        step();
        drive(1'b1, 0, 2, 32'h102);
        step();
        cmd_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (slot_write) begin
            if (nw == 0) first = c;
            check("b2b_consec", 64'(c), 64'(first + nw));
            check("b2b_addr", 64'(slot_addr), 64'(nw));
            check("b2b_wdata", 64'(slot_wdata), 64'(32'h100 + 32'(nw)));
            check("b2b_cs", 64'(slot_cs), 64'd1);
            nw++;
          end
        end
      end
    join
    check("b2b_count", 64'(nw), 64'd3);
    step();

    // top slot / top register
    drive(1'b0, 63, 31, 32'd0);
    step();
    cmd_valid = 1'b0;
    step();
    @(negedge clk);
    check("s63_cs", 64'(slot_cs), 64'h8000_0000_0000_0000);
    check("s63_addr", 64'(slot_addr), 64'd31);
    check("s63_read", 64'(slot_read), 64'd1);
    wait_rsp("s63_rsp_timeout");
    check("s63_rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // reset while a write strobe is active
    drive(1'b1, 2, 4, 32'h55);
    step();
    cmd_valid = 1'b0;
    step();
    @(negedge clk);
    check("rstw_pre", 64'(slot_write), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rstw_write", 64'(slot_write), 64'd0);
    check("rstw_cs", 64'(slot_cs), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // reset while a response is pending
    drive(1'b0, 6, 2, 32'd0);
    step();
    cmd_valid = 1'b0;
    wait_rsp("rstr_rsp_timeout");
    check("rstr_pre_valid", 64'(rsp_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rstr_valid", 64'(rsp_valid), 64'd0);
    check("rstr_cs", 64'(slot_cs), 64'd0);
    check("rstr_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    check("rstr_cmd_ready", 64'(cmd_ready), 64'd1);
    k = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid || busy) k++;
    end
    check("rstr_no_replay", 64'(k), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
